mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide sequencer that sits in the EX stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo from the EX-stage control and holds the architectural HI/LO registers. It runs a fixed-latency busy window so the hazard unit can stall HI/LO consumers and new MD instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
start  input  1  EX-stage instruction is an MD op; qualifies md_op
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
src_a  input  32  forwarded rs value
src_b  input  32  forwarded rt value
busy  output  1  MD operation in flight
stall_req  output  1  busy | (start & md_op<=3); combinational, to hazard unit
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, hi=0, lo=0, busy=0, and pending result registers = 0. Reset is honoured mid-operation; the in-flight result is discarded.
- States: IDLE, RUN. cnt is 4 bits.
- IDLE with start=1 and md_op in 0..3, sampled at edge E:
  - Latch the operands and compute the pending {phi,plo} at E.
  - cnt <= MULT_CYCLES for ops 0/1, or DIV_CYCLES for ops 2/3.
  - state <= RUN.
- RUN:
  - busy=1 for exactly N cycles after E.
  - Each edge decrements cnt.
  - At the edge where cnt==1: hi<=phi, lo<=plo, state<=IDLE.
  - New hi/lo are visible in cycle E+N+1, and busy=0 in that cycle.
- Arithmetic:
  - MULT: {HI,LO} = signed 32x32 -> 64-bit product.
  - MULTU: {HI,LO} = unsigned 32x32 -> 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (src_a / src_b).
  - DIVU: unsigned LO = quotient, HI = remainder.
- Divide by zero (src_b==0): the full busy window runs, but hi/lo are left unchanged at commit.
- DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- MTHI/MTLO in IDLE: hi (or lo) <= src_a at the next edge. busy is not asserted. stall_req stays 0 for these ops.
- Any start while in RUN is ignored; no state change. The pipeline guarantees this does not happen via stall_req.
- md_op 6/7 with start=1: no effect.
- busy is a registered output: it equals (state==RUN).
- stall_req is combinational. It covers the issue cycle, so a dependent mfhi/mflo one stage behind is stalled immediately.

Decomposition:
- Shared CPU parameter file: MD op encodings (MD_MULT..MD_MTLO) and the default latency constants.
- One natural sub-module, mdu_arith: purely combinational.
  - Inputs: op, a, b.
  - Outputs: 64-bit {hi,lo} result and a div_by_zero flag.
- The sequencer itself owns the FSM, the counter and the HI/LO registers.

Test Plan:
- Reset, then start MULT with a=0xFFFFFFFE (-2), b=3 -> busy=1 for exactly 5 cycles; the cycle after, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV with a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 (prior hi/lo = 0x11/0x22) -> 10 busy cycles; hi/lo remain 0x11/0x22.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234 and lo=0x5678 one edge after each; busy and stall_req stay 0 throughout.
- During RUN of a DIV, pulse start with MULT a=1, b=1 and MTHI a=0xDEAD -> both ignored; the final hi/lo match the DIV result only. stall_req=1 on the issue cycle and on every busy cycle.
- Assert reset (low) in the 3rd busy cycle of a MULT -> busy, hi and lo drop to 0 immediately, without waiting for a clock edge. After release, a MTLO a=5 gives lo=5 the next edge.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer_pkg
//  Description : Shared MD op encodings, default latencies and FSM state type
//                for the EX-stage multiply/divide sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_sequencer_pkg;

  // EX-stage MD op encodings carried on md_op
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default busy-window lengths
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Ops that open a busy window (mult/multu/div/divu)
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer_if
//  Description : Issue/result bundle between EX-stage control and the MD
//                sequencer. master = EX control, slave = sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_sequencer_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, src_a, src_b,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, src_a, src_b,
    output busy, stall_req, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_sequencer_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Combinational multiply/divide datapath. Produces the 64-bit
//                {hi,lo} result of an MD op and flags divide-by-zero.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic               w_b_zero;
  logic               w_sovf;
  logic [31:0]        w_b_udiv;
  logic [31:0]        w_b_sdiv;
  logic signed [63:0] w_sprod;
  logic [63:0]        w_uprod;
  logic [31:0]        w_squot;
  logic [31:0]        w_srem;
  logic [31:0]        w_uquot;
  logic [31:0]        w_urem;

  assign w_b_zero = (b == 32'd0);
  // -2^31 / -1 overflows 32 bits; dividing by 1 instead yields the wrapped
  // quotient 0x80000000 with remainder 0, which is the required result.
  assign w_sovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Keep the dividers away from a zero divisor; the result is discarded then.
  assign w_b_udiv = w_b_zero ? 32'd1 : b;
  assign w_b_sdiv = (w_b_zero || w_sovf) ? 32'd1 : b;

  assign w_sprod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_uprod  = {32'd0, a} * {32'd0, b};

  // Signed / and % truncate toward zero; remainder follows the dividend sign.
  assign w_squot  = $signed(a) / $signed(w_b_sdiv);
  assign w_srem   = $signed(a) % $signed(w_b_sdiv);
  assign w_uquot  = a / w_b_udiv;
  assign w_urem   = a % w_b_udiv;

  // Select the result for the requested op
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = w_sprod;
      MD_MULTU: result = w_uprod;
      MD_DIV: begin
        result      = {w_srem, w_squot};
        div_by_zero = w_b_zero;
      end
      MD_DIVU: begin
        result      = {w_urem, w_uquot};
        div_by_zero = w_b_zero;
      end
      default:  result = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sequencer
//  Description : EX-stage multiply/divide sequencer. Owns HI/LO, computes the
//                result at issue and commits it after a fixed busy window so
//                the hazard unit can stall HI/LO consumers.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mdu_sequencer_if.slave    md
);

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  mdu_state_t  r_state;
  mdu_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_pdz;

  logic        w_issue;
  logic        w_commit;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic [63:0] w_result;
  logic        w_div_by_zero;

  mdu_arith u_arith (
    .op          (md.md_op),
    .a           (md.src_a),
    .b           (md.src_b),
    .result      (w_result),
    .div_by_zero (w_div_by_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle actions; starts during RUN are ignored
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_commit    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (md.start) begin
          if (is_arith_op(md.md_op)) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_RUN;
          end else if (md.md_op == MD_MTHI) begin
            w_mt_hi = 1'b1;
          end else if (md.md_op == MD_MTLO) begin
            w_mt_lo = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Busy counter and pending result captured at issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_pdz <= 1'b0;
    end else if (w_issue) begin
      r_cnt <= md.md_op[1] ? c_div_cnt : c_mult_cnt;
      r_phi <= w_result[63:32];
      r_plo <= w_result[31:0];
      r_pdz <= w_div_by_zero;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Architectural HI/LO: commit at end of window (unless /0), or mthi/mtlo
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_commit && !r_pdz) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
      if (w_mt_hi) begin
        r_hi <= md.src_a;
      end
      if (w_mt_lo) begin
        r_lo <= md.src_a;
      end
    end
  end

  // stall_req covers the issue cycle so a dependent mfhi/mflo stalls at once
  assign md.busy      = (r_state == ST_RUN);
  assign md.stall_req = (r_state == ST_RUN) || (md.start && is_arith_op(md.md_op));
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sequencer
//  Description : Self-checking bench for mdu_sequencer: behavioural model of
//                HI/LO/busy, per-cycle compare, directed and random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_sequencer_if u_if();

  mdu_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_left = 0;      // busy cycles still to run
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [31:0] p_hi   = 32'd0;
  logic [31:0] p_lo   = 32'd0;
  bit          p_dz   = 1'b0;

  function automatic void md_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint          sa, sb, q, r;
    logic [63:0]     p;
    h = 32'd0; l = 32'd0; dz = 1'b0;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      MD_MULTU: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
      MD_DIV: begin
        if (b == 32'd0) dz = 1'b1;
        else begin q = sa / sb; r = sa - q * sb; l = q[31:0]; h = r[31:0]; end
      end
      MD_DIVU: begin
        if (b == 32'd0) dz = 1'b1;
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !p_dz) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (u_if.start) begin
      if (u_if.md_op <= MD_DIVU) begin
        md_calc(u_if.md_op, u_if.src_a, u_if.src_b, p_hi, p_lo, p_dz);
        m_left = (u_if.md_op >= MD_DIV) ? 10 : 5;
      end else if (u_if.md_op == MD_MTHI) m_hi = u_if.src_a;
      else if (u_if.md_op == MD_MTLO) m_lo = u_if.src_a;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("busy", {31'd0, u_if.busy}, {31'd0, m_left > 0});
    check("stall_req", {31'd0, u_if.stall_req},
          {31'd0, (m_left > 0) || (u_if.start && u_if.md_op <= MD_DIVU)});
    check("hi", u_if.hi, m_hi);
    check("lo", u_if.lo, m_lo);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    u_if.start = s; u_if.md_op = op; u_if.src_a = a; u_if.src_b = b;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Count busy cycles starting from the first cycle after issue (bounded)
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!u_if.busy) break;
      n++;
      tick();
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    drive(1'b1, op, a, b);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    wait_idle(n);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed then random ----------------
  initial begin
    int n;
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    repeat (3) tick();
    check("reset_busy", {31'd0, u_if.busy}, 32'd0);
    check("reset_hi", u_if.hi, 32'd0);
    check("reset_lo", u_if.lo, 32'd0);
    reset = 1'b1;
    tick();

    // MULT -2 * 3
    drive(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3);
    #1 check("mult_issue_stall", {31'd0, u_if.stall_req}, 32'd1);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    wait_idle(n);
    check("mult_busy_len", 32'(n), 32'd5);
    check("mult_hi", u_if.hi, 32'hFFFF_FFFF);
    check("mult_lo", u_if.lo, 32'hFFFF_FFFA);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_busy_len", 32'(n), 32'd5);
    check("multu_hi", u_if.hi, 32'hFFFF_FFFE);
    check("multu_lo", u_if.lo, 32'h0000_0001);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, n);
    check("div_busy_len", 32'(n), 32'd10);
    check("div_lo", u_if.lo, 32'hFFFF_FFFD);
    check("div_hi", u_if.hi, 32'hFFFF_FFFF);

    drive(1'b1, MD_MTHI, 32'h11, 32'd0); tick();
    drive(1'b1, MD_MTLO, 32'h22, 32'd0); tick();
    run_op(MD_DIVU, 32'd7, 32'd0, n);
    check("divz_busy_len", 32'(n), 32'd10);
    check("divz_hi", u_if.hi, 32'h11);
    check("divz_lo", u_if.lo, 32'h22);

    // MTHI then MTLO back to back
    drive(1'b1, MD_MTHI, 32'h1234, 32'd0);
    #1 check("mthi_stall", {31'd0, u_if.stall_req}, 32'd0);
    tick();
    check("mthi_hi", u_if.hi, 32'h1234);
    drive(1'b1, MD_MTLO, 32'h5678, 32'd0);
    #1 check("mtlo_stall", {31'd0, u_if.stall_req}, 32'd0);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    check("mtlo_lo", u_if.lo, 32'h5678);
    check("mt_busy", {31'd0, u_if.busy}, 32'd0);

    // Starts during RUN of a DIV are ignored
    drive(1'b1, MD_DIV, 32'd100, 32'd7);
    tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!u_if.busy) break;
      n++;
      check("run_stall", {31'd0, u_if.stall_req}, 32'd1);
      if (i == 1)      drive(1'b1, MD_MULT, 32'd1, 32'd1);
      else if (i == 3) drive(1'b1, MD_MTHI, 32'hDEAD, 32'd0);
      else             drive(1'b0, 3'd7, 32'd0, 32'd0);
      tick();
    end
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    check("ign_busy_len", 32'(n), 32'd10);
    check("ign_hi", u_if.hi, 32'd2);
    check("ign_lo", u_if.lo, 32'd14);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("ovf_lo", u_if.lo, 32'h8000_0000);
    check("ovf_hi", u_if.hi, 32'd0);

    // Asynchronous reset in the 3rd busy cycle of a MULT
    drive(1'b1, MD_MTHI, 32'hABCD, 32'd0); tick();
    drive(1'b1, MD_MULT, 32'd3, 32'd4); tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, u_if.busy}, 32'd0);
    check("arst_hi", u_if.hi, 32'd0);
    check("arst_lo", u_if.lo, 32'h8000_0000 & 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    drive(1'b1, MD_MTLO, 32'd5, 32'd0); tick();
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    check("post_rst_lo", u_if.lo, 32'd5);

    // Random traffic, including starts during RUN and rare resets
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      if ($urandom_range(0, 9) < 5)
        drive(1'b1, 3'($urandom_range(0, 7)), pick(), pick());
      else
        drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      tick();
    end
    drive(1'b0, 3'd7, 32'd0, 32'd0);
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
